// File: rtl/braille_spi_frame_receiver.sv
// SPI mode-0 slave frame receiver: oversamples sclk/mosi/ss_n on the system clock,
// assembles MSB-first DATA_WIDTH frames and shifts a readback word out on miso.
module braille_spi_frame_receiver #(
  parameter int DATA_WIDTH  = 16,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = 5
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  sclk,
  input  logic                  mosi,
  input  logic                  ss_n,
  output logic                  miso,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  frame_error,
  output logic                  busy,
  output logic [1:0]            state_dbg
);

  // rx_valid / frame_error are single-cycle strobes with no back-pressure: rx_data is
  // valid in the strobe cycle and holds until the next good frame or a reset.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(DATA_WIDTH);
  localparam logic [CNT_WIDTH-1:0] CNT_OVR  = CNT_WIDTH'(DATA_WIDTH + 1);

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
  logic                   sclk_s, mosi_s, ss_n_s;

  logic                   sclk_dly_q, sclk_dly_d;
  logic                   ss_dly_q, ss_dly_d;
  logic                   sclk_rise_q, sclk_rise_d;
  logic                   sclk_fall_q, sclk_fall_d;
  logic                   ss_rise_q, ss_rise_d;
  logic                   ss_fall_q, ss_fall_d;
  logic                   mosi_q, mosi_d;

  logic [SYNC_STAGES:0]   fill_q, fill_d;
  logic                   start_armed_q, start_armed_d;

  state_t                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-1:0]  rx_shift_q, rx_shift_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]  rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   frame_error_q, frame_error_d;
  logic                   busy_q, busy_d;
  logic                   miso_q, miso_d;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  assign ss_n_s = ss_sync_q[SYNC_STAGES-1];

  // Synchronizers, delayed copies and registered edge flags.
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], ss_n};
    sclk_dly_d  = sclk_s;
    ss_dly_d    = ss_n_s;
    sclk_rise_d = sclk_s & ~sclk_dly_q;
    sclk_fall_d = ~sclk_s & sclk_dly_q;
    ss_rise_d   = ss_n_s & ~ss_dly_q;
    ss_fall_d   = ~ss_n_s & ss_dly_q;
    mosi_d      = mosi_s;
    fill_d      = {fill_q[SYNC_STAGES-1:0], 1'b1};
    // The ss_n chain resets high, so a high level only counts once real pin samples
    // have flushed through; otherwise a low pin at reset release would start a frame.
    start_armed_d = start_armed_q | ((&fill_q) & ss_n_s);
  end

  always_comb begin
    state_d       = state_q;
    tx_shift_d    = tx_shift_q;
    rx_shift_d    = rx_shift_q;
    cnt_d         = cnt_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    frame_error_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (ss_fall_q && start_armed_q) begin
          tx_shift_d = tx_data;
          rx_shift_d = '0;
          cnt_d      = '0;
          state_d    = ACTIVE;
        end
      end
      ACTIVE: begin
        if (ss_rise_q) begin
          // Frame end wins over any sclk edge seen in the same cycle.
          if (cnt_q == CNT_FULL) begin
            rx_data_d  = rx_shift_q;
            rx_valid_d = 1'b1;
          end else begin
            frame_error_d = 1'b1;
          end
          state_d = IDLE;
        end else begin
          if (sclk_rise_q) begin
            rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_q};
            cnt_d      = (cnt_q == CNT_OVR) ? cnt_q : cnt_q + 1'b1;
          end
          if (sclk_fall_q && (cnt_q != '0)) begin
            tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == ACTIVE);
    miso_d = busy_d ? tx_shift_d[DATA_WIDTH-1] : 1'b0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync_q   <= '0;
      mosi_sync_q   <= '0;
      ss_sync_q     <= '1;
      sclk_dly_q    <= 1'b0;
      ss_dly_q      <= 1'b1;
      sclk_rise_q   <= 1'b0;
      sclk_fall_q   <= 1'b0;
      ss_rise_q     <= 1'b0;
      ss_fall_q     <= 1'b0;
      mosi_q        <= 1'b0;
      fill_q        <= '0;
      start_armed_q <= 1'b0;
      state_q       <= IDLE;
      tx_shift_q    <= '0;
      rx_shift_q    <= '0;
      cnt_q         <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      frame_error_q <= 1'b0;
      busy_q        <= 1'b0;
      miso_q        <= 1'b0;
    end else begin
      sclk_sync_q   <= sclk_sync_d;
      mosi_sync_q   <= mosi_sync_d;
      ss_sync_q     <= ss_sync_d;
      sclk_dly_q    <= sclk_dly_d;
      ss_dly_q      <= ss_dly_d;
      sclk_rise_q   <= sclk_rise_d;
      sclk_fall_q   <= sclk_fall_d;
      ss_rise_q     <= ss_rise_d;
      ss_fall_q     <= ss_fall_d;
      mosi_q        <= mosi_d;
      fill_q        <= fill_d;
      start_armed_q <= start_armed_d;
      state_q       <= state_d;
      tx_shift_q    <= tx_shift_d;
      rx_shift_q    <= rx_shift_d;
      cnt_q         <= cnt_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      frame_error_q <= frame_error_d;
      busy_q        <= busy_d;
      miso_q        <= miso_d;
    end
  end

  assign miso        = miso_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign frame_error = frame_error_q;
  assign busy        = busy_q;
  assign state_dbg   = state_q;

endmodule
